// File: rtl/vscale_periph_mux.sv
// HASTI slave-side fan-out: decodes one index field of haddr into N slave selects
// and routes the data-phase response back; unpopulated ports get a two-cycle ERROR.
module vscale_periph_mux #(
    parameter int unsigned SEL_BITS = 2,
    parameter int unsigned SEL_LSB  = 4,
    parameter logic [(2**SEL_BITS)-1:0] SLAVE_EN = '1,
    localparam int unsigned N        = 2**SEL_BITS,
    localparam int unsigned ADDR_W   = 32,
    localparam int unsigned BUS_W    = 32,
    localparam int unsigned SIZE_W   = 3,
    localparam int unsigned BURST_W  = 3,
    localparam int unsigned PROT_W   = 4,
    localparam int unsigned TRANS_W  = 2,
    localparam int unsigned RESP_W   = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  hsel,
    input  logic [ADDR_W-1:0]     haddr,
    input  logic                  hwrite,
    input  logic [SIZE_W-1:0]     hsize,
    input  logic [BURST_W-1:0]    hburst,
    input  logic                  hmastlock,
    input  logic [PROT_W-1:0]     hprot,
    input  logic [TRANS_W-1:0]    htrans,
    input  logic [BUS_W-1:0]      hwdata,
    output logic [BUS_W-1:0]      hrdata,
    output logic                  hready,
    output logic [RESP_W-1:0]     hresp,

    output logic [N-1:0]          s_hsel,
    output logic [ADDR_W-1:0]     s_haddr,
    output logic                  s_hwrite,
    output logic [SIZE_W-1:0]     s_hsize,
    output logic [BURST_W-1:0]    s_hburst,
    output logic                  s_hmastlock,
    output logic [PROT_W-1:0]     s_hprot,
    output logic [TRANS_W-1:0]    s_htrans,
    output logic [BUS_W-1:0]      s_hwdata,
    input  logic [N*BUS_W-1:0]    s_hrdata,
    input  logic [N-1:0]          s_hready,
    input  logic [N*RESP_W-1:0]   s_hresp,

    output logic [7:0]            err_count,
    output logic [ADDR_W-1:0]     err_addr
);

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SLV  = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    logic [1:0]          r_state;
    logic [SEL_BITS-1:0] r_dp_idx;
    logic [7:0]          r_err_count;
    logic [ADDR_W-1:0]   r_err_addr;

    logic [1:0]          w_state_d;
    logic [SEL_BITS-1:0] w_dp_idx_d;
    logic [SEL_BITS-1:0] w_idx;
    logic                w_idx_en;
    logic                w_accept;
    logic                w_err_hit;
    logic                w_hready;
    logic [RESP_W-1:0]   w_hresp;
    logic [BUS_W-1:0]    w_hrdata;

    assign w_idx    = haddr[SEL_LSB +: SEL_BITS];
    assign w_idx_en = SLAVE_EN[w_idx];
    assign w_accept = hsel & w_hready;

    always_comb begin
        s_hsel = '0;
        for (int i = 0; i < int'(N); i++) begin
            s_hsel[i] = hsel & (w_idx == SEL_BITS'(i)) & SLAVE_EN[i];
        end
    end

    assign s_haddr     = haddr;
    assign s_hwrite    = hwrite;
    assign s_hsize     = hsize;
    assign s_hburst    = hburst;
    assign s_hmastlock = hmastlock;
    assign s_hprot     = hprot;
    assign s_htrans    = htrans;
    assign s_hwdata    = hwdata;

    // Response path is purely combinational from the registered data-phase routing.
    always_comb begin
        w_hready = 1'b1;
        w_hresp  = '0;
        w_hrdata = '0;
        case (r_state)
            ST_SLV: begin
                w_hready = s_hready[r_dp_idx];
                w_hresp  = s_hresp[r_dp_idx*RESP_W +: RESP_W];
                w_hrdata = s_hrdata[r_dp_idx*BUS_W +: BUS_W];
            end
            ST_ERR1: begin
                w_hready = 1'b0;
                w_hresp  = RESP_W'(1);
            end
            ST_ERR2: begin
                w_hresp  = RESP_W'(1);
            end
            default: ;
        endcase
    end

    assign hready = w_hready;
    assign hresp  = w_hresp;
    assign hrdata = w_hrdata;

    // htrans[1] set means NONSEQ or SEQ; IDLE/BUSY never raise a decode error.
    always_comb begin
        w_state_d  = r_state;
        w_dp_idx_d = r_dp_idx;
        w_err_hit  = 1'b0;
        if (r_state == ST_ERR1) begin
            w_state_d = ST_ERR2;
        end else if (w_hready) begin
            if (w_accept && htrans[1]) begin
                if (w_idx_en) begin
                    w_state_d  = ST_SLV;
                    w_dp_idx_d = w_idx;
                end else begin
                    w_state_d = ST_ERR1;
                    w_err_hit = 1'b1;
                end
            end else begin
                w_state_d = ST_NONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_NONE;
            r_dp_idx    <= '0;
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_dp_idx <= w_dp_idx_d;
            if (w_err_hit) begin
                r_err_addr <= haddr;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign err_count = r_err_count;
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_vscale_periph_mux.sv
// Directed bench for vscale_periph_mux with ports 0 and 1 populated out of four.
module tb_vscale_periph_mux;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          hsel;
    logic [31:0]   haddr;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic          hmastlock;
    logic [3:0]    hprot;
    logic [1:0]    htrans;
    logic [31:0]   hwdata;
    logic [31:0]   hrdata;
    logic          hready;
    logic          hresp;
    logic [N-1:0]  s_hsel;
    logic [31:0]   s_haddr;
    logic          s_hwrite;
    logic [2:0]    s_hsize;
    logic [2:0]    s_hburst;
    logic          s_hmastlock;
    logic [3:0]    s_hprot;
    logic [1:0]    s_htrans;
    logic [31:0]   s_hwdata;
    logic [N*32-1:0] s_hrdata;
    logic [N-1:0]  s_hready;
    logic [N-1:0]  s_hresp;
    logic [7:0]    err_count;
    logic [31:0]   err_addr;

    int n_tests = 0;
    int n_fail  = 0;

    vscale_periph_mux #(
        .SEL_BITS (2),
        .SEL_LSB  (4),
        .SLAVE_EN (4'b0011)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hsel        (hsel),
        .haddr       (haddr),
        .hwrite      (hwrite),
        .hsize       (hsize),
        .hburst      (hburst),
        .hmastlock   (hmastlock),
        .hprot       (hprot),
        .htrans      (htrans),
        .hwdata      (hwdata),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp),
        .s_hsel      (s_hsel),
        .s_haddr     (s_haddr),
        .s_hwrite    (s_hwrite),
        .s_hsize     (s_hsize),
        .s_hburst    (s_hburst),
        .s_hmastlock (s_hmastlock),
        .s_hprot     (s_hprot),
        .s_htrans    (s_htrans),
        .s_hwdata    (s_hwdata),
        .s_hrdata    (s_hrdata),
        .s_hready    (s_hready),
        .s_hresp     (s_hresp),
        .err_count   (err_count),
        .err_addr    (err_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] slice_data(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ap(input logic sel, input logic [31:0] addr, input logic wr,
                            input logic [1:0] trans);
        hsel   = sel;
        haddr  = addr;
        hwrite = wr;
        htrans = trans;
        #1;
    endtask

    task automatic check_resp(input string tag, input logic rdy, input logic rsp,
                              input logic [31:0] data);
        check_eq({tag, "_hready"}, 32'(hready), 32'(rdy));
        check_eq({tag, "_hresp"},  32'(hresp),  32'(rsp));
        check_eq({tag, "_hrdata"}, hrdata,      data);
    endtask

    initial begin
        reset     = 1'b1;
        hsel      = 1'b0;
        haddr     = '0;
        hwrite    = 1'b0;
        hsize     = 3'd2;
        hburst    = 3'd0;
        hmastlock = 1'b0;
        hprot     = 4'h3;
        htrans    = 2'd0;
        hwdata    = 32'h5A5A_1234;
        s_hready  = '1;
        s_hresp   = '0;
        for (int i = 0; i < N; i++) s_hrdata[i*32 +: 32] = slice_data(i);
        #1;

        // Reset values
        check_resp("rst", 1'b1, 1'b0, 32'h0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        check_eq("rst_err_addr", err_addr, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // NONSEQ read to port 1
        drive_ap(1'b1, 32'h10, 1'b0, 2'd2);
        check_eq("rd10_s_hsel", 32'(s_hsel), 32'h2);
        check_eq("rd10_s_haddr", s_haddr, 32'h10);
        check_eq("rd10_s_hwdata", s_hwdata, 32'h5A5A_1234);
        tick();
        drive_ap(1'b0, 32'h0, 1'b0, 2'd0);
        check_resp("rd10_dp", 1'b1, 1'b0, slice_data(1));
        tick();
        check_resp("rd10_idle", 1'b1, 1'b0, 32'h0);

        // Slave 1 stalls while the next address targets port 0
        drive_ap(1'b1, 32'h10, 1'b0, 2'd2);
        tick();
        s_hready = 4'b1101;
        drive_ap(1'b1, 32'h00, 1'b0, 2'd2);
        for (int k = 0; k < 3; k++) begin
            check_resp($sformatf("wait%0d", k), 1'b0, 1'b0, slice_data(1));
            check_eq($sformatf("wait%0d_s_hsel", k), 32'(s_hsel), 32'h1);
            tick();
        end
        s_hready = '1;
        #1;
        check_resp("wait_done", 1'b1, 1'b0, slice_data(1));
        tick();
        drive_ap(1'b0, 32'h0, 1'b0, 2'd0);
        check_resp("after_wait_p0", 1'b1, 1'b0, slice_data(0));
        tick();

        // NONSEQ write to disabled port 2
        drive_ap(1'b1, 32'h20, 1'b1, 2'd2);
        check_eq("wr20_s_hsel", 32'(s_hsel), 32'h0);
        tick();
        drive_ap(1'b0, 32'h0, 1'b0, 2'd0);
        check_resp("wr20_err1", 1'b0, 1'b1, 32'h0);
        tick();
        check_resp("wr20_err2", 1'b1, 1'b1, 32'h0);
        check_eq("wr20_err_count", 32'(err_count), 32'd1);
        check_eq("wr20_err_addr", err_addr, 32'h20);
        tick();
        check_resp("wr20_done", 1'b1, 1'b0, 32'h0);

        // 256 back-to-back decode errors to port 3; count saturates
        drive_ap(1'b1, 32'h30, 1'b0, 2'd2);
        for (int i = 0; i < 256; i++) begin
            tick();
            tick();
            if (i == 127) check_eq("sat_mid_count", 32'(err_count), 32'd129);
        end
        check_resp("sat_err2", 1'b1, 1'b1, 32'h0);
        check_eq("sat_err_count", 32'(err_count), 32'd255);
        check_eq("sat_err_addr", err_addr, 32'h30);
        drive_ap(1'b1, 32'h30, 1'b0, 2'd0);
        tick();
        drive_ap(1'b1, 32'h24, 1'b0, 2'd1);
        check_resp("idle30_okay", 1'b1, 1'b0, 32'h0);
        tick();
        drive_ap(1'b0, 32'h0, 1'b0, 2'd0);
        check_resp("busy24_okay", 1'b1, 1'b0, 32'h0);
        check_eq("idle_err_count", 32'(err_count), 32'd255);
        check_eq("idle_err_addr", err_addr, 32'h30);
        tick();

        // Back-to-back reads 0x00, 0x10, 0x04
        drive_ap(1'b1, 32'h00, 1'b0, 2'd2);
        tick();
        drive_ap(1'b1, 32'h10, 1'b0, 2'd3);
        check_resp("b2b_0", 1'b1, 1'b0, slice_data(0));
        tick();
        drive_ap(1'b1, 32'h04, 1'b0, 2'd2);
        s_hresp = 4'b0010;
        #1;
        check_resp("b2b_1", 1'b1, 1'b1, slice_data(1));
        tick();
        drive_ap(1'b0, 32'h0, 1'b0, 2'd0);
        check_resp("b2b_2", 1'b1, 1'b0, slice_data(0));
        s_hresp = '0;
        tick();

        // Reset pulse while in ERR1
        drive_ap(1'b1, 32'h20, 1'b0, 2'd2);
        tick();
        drive_ap(1'b0, 32'h0, 1'b0, 2'd0);
        check_resp("rst_err1_pre", 1'b0, 1'b1, 32'h0);
        check_eq("rst_err1_pre_count", 32'(err_count), 32'd255);
        reset = 1'b1;
        #1;
        check_resp("rst_err1_async", 1'b1, 1'b0, 32'h0);
        check_eq("rst_err1_count", 32'(err_count), 32'd0);
        check_eq("rst_err1_addr", err_addr, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check_resp("rst_release", 1'b1, 1'b0, 32'h0);
        tick();
        check_resp("rst_after", 1'b1, 1'b0, 32'h0);
        check_eq("rst_after_count", 32'(err_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vscale_periph_mux.md
VSCALE_PERIPH_MUX -- requirements
Module: vscale_periph_mux

Interface
REQ-001 SHALL have parameter SEL_BITS, default 2, giving N = 2**SEL_BITS slave ports.
REQ-002 SHALL have parameter SEL_LSB, default 4, the lowest haddr bit of the slave index field haddr[SEL_LSB +: SEL_BITS].
REQ-003 SHALL have parameter SLAVE_EN, N bits, default all ones; bit i=1 means port i is populated.
REQ-004 SHALL use HASTI widths for all bus ports: ADDR, BUS, SIZE, BURST, PROT, TRANS, RESP.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have upstream slave-side inputs hsel, haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata.
REQ-008 SHALL have upstream outputs hrdata (BUS), hready (1), hresp (RESP).
REQ-009 SHALL have outputs s_hsel (N), plus s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans, s_hwdata, broadcast unchanged from upstream.
REQ-010 SHALL have inputs s_hrdata (N*BUS), s_hready (N), s_hresp (N*RESP); port i occupies slice i.
REQ-011 SHALL have outputs err_count (8), the saturating decode-error count, and err_addr (ADDR), the haddr of the last decode error.

Function
REQ-012 SHALL compute idx = haddr[SEL_LSB +: SEL_BITS] combinationally.
REQ-013 SHALL drive s_hsel[i] = hsel & (idx==i) & SLAVE_EN[i]; all other bits SHALL be 0.
REQ-014 SHALL accept an address phase only when hsel & hready (own hready output) are both 1.
REQ-015 SHALL keep a data-phase FSM with states NONE, SLV, ERR1, ERR2; reset state NONE.
REQ-016 SHALL transition on an accepted phase with htrans NONSEQ(2) or SEQ(3) and SLAVE_EN[idx]=1 to SLV, registering dp_idx=idx.
REQ-017 SHALL transition on an accepted phase with htrans NONSEQ/SEQ and SLAVE_EN[idx]=0 to ERR1, registering err_addr=haddr and err_count+1, saturating at 255.
REQ-018 SHALL transition to NONE on an accepted phase with htrans IDLE(0)/BUSY(1), or when no phase is accepted and the data phase completes.
REQ-019 SHALL in NONE drive hready=1, hresp=OKAY(0), hrdata=0.
REQ-020 SHALL in SLV drive hready, hresp and hrdata from slice dp_idx; the state and dp_idx SHALL be held while s_hready[dp_idx]=0.
REQ-021 SHALL in ERR1 drive hready=0, hresp=ERROR(1); it SHALL go unconditionally to ERR2.
REQ-022 SHALL in ERR2 drive hready=1, hresp=ERROR(1); the next state SHALL come from the address phase presented in that cycle.
REQ-023 SHALL make hrdata 0 in ERR1/ERR2.
REQ-024 SHALL update dp_idx/state only on hready=1 cycles, so a slave wait state freezes routing (no address-phase decode leakage).
REQ-025 SHALL support back-to-back pipelined transfers to different ports with zero added latency; the mux adds no registers in the hready or hrdata path beyond dp_idx/state.
REQ-026 SHALL NOT change err_count or err_addr when an accepted IDLE/BUSY phase targets a disabled port; that phase gets an OKAY response.

Reset
REQ-027 SHALL, while reset=1, asynchronously force state=NONE, dp_idx=0, err_count=0, err_addr=0, giving hready=1, hresp=0, hrdata=0.
REQ-028 SHALL treat reset asserted mid-transfer (SLV or ERR1) as abandoning the transfer; the first cycle after release SHALL be NONE.

Verification
REQ-029 Bench SHALL cover, with SEL_BITS=2, SEL_LSB=4, SLAVE_EN=4'b0011: NONSEQ read 0x10 -> s_hsel=4'b0010; next cycle hrdata = slice1 data, hresp=0.
REQ-030 Bench SHALL cover: slave1 holds s_hready=0 for 3 cycles while the next address 0x00 is presented -> hready=0 for 3 cycles, s_hsel[0] asserted but not accepted until hready=1, data routed only from slice1.
REQ-031 Bench SHALL cover: NONSEQ write 0x20 (disabled) -> s_hsel=0; hready/hresp = 0/1 then 1/1; err_count=1; err_addr=0x20.
REQ-032 Bench SHALL cover: 256 consecutive decode errors -> err_count saturates at 255; IDLE to 0x30 -> OKAY, count unchanged.
REQ-033 Bench SHALL cover: back-to-back reads 0x00, 0x10, 0x04 with zero wait states -> responses from slices 0,1,0 in consecutive cycles.
REQ-034 Bench SHALL cover: reset pulsed during ERR1 -> outputs immediately hready=1, hresp=0, err_count=0.
